// File: rtl/mem_responder_pkg.sv
// ----------------------------------------------------------------------------
// mem_responder_pkg
//   Types shared between the 8008 memory responder, its bus interface and the
//   testbench: the core timing state encoding, the cycle type carried in
//   cpu_d[7:6] during T2, and the default memory address width.
// ----------------------------------------------------------------------------
package mem_responder_pkg;

    localparam int ADDR_W_DEFAULT = 14;

    // Core timing state as reported by the 8008 core model.
    typedef enum logic [2:0] {
        T1      = 3'd0,
        T1I     = 3'd1,
        T2      = 3'd2,
        WAIT    = 3'd3,
        T3      = 3'd4,
        T4      = 3'd5,
        T5      = 3'd6,
        STOPPED = 3'd7
    } state_t;

    // Cycle type sent by the core in the upper two bits of the T2 byte.
    typedef enum logic [1:0] {
        PCI = 2'b00,  // instruction fetch
        PCR = 2'b01,  // memory read
        PCC = 2'b10,  // I/O command
        PCW = 2'b11   // memory write
    } cyc_type_t;

    // T1 and T1I both carry the low address byte.
    function automatic logic is_addr_lo_state(state_t s);
        return (s == T1) || (s == T1I);
    endfunction

endpackage

// File: rtl/mem_responder_if.sv
// ----------------------------------------------------------------------------
// mem_responder_if
//   Bundles the core-side and memory-side signals of the responder.
//   Modports:
//     slave  - the responder: consumes core state/data and memory replies,
//              drives read data, ready, memory request and I/O strobe.
//     master - the environment (core + memory + I/O): the mirror image.
//   Signals:
//     state, sync, cpu_d, int_instr   core -> responder
//     rsp_d, rsp_oe, ready            responder -> core
//     mem_req, mem_we, mem_addr,
//     mem_wdata                       responder -> memory
//     mem_rdata, mem_ack              memory -> responder
//     io_strobe, io_port, io_data     responder -> I/O
// ----------------------------------------------------------------------------
interface mem_responder_if
    import mem_responder_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEFAULT
) ();

    state_t              state;
    logic                sync;
    logic [7:0]          cpu_d;
    logic [7:0]          int_instr;
    logic [7:0]          rsp_d;
    logic                rsp_oe;
    logic                ready;
    logic                mem_req;
    logic                mem_we;
    logic [ADDR_W-1:0]   mem_addr;
    logic [7:0]          mem_wdata;
    logic [7:0]          mem_rdata;
    logic                mem_ack;
    logic                io_strobe;
    logic [4:0]          io_port;
    logic [7:0]          io_data;

    modport slave (
        input  state, sync, cpu_d, int_instr, mem_rdata, mem_ack,
        output rsp_d, rsp_oe, ready, mem_req, mem_we, mem_addr, mem_wdata,
               io_strobe, io_port, io_data
    );

    modport master (
        output state, sync, cpu_d, int_instr, mem_rdata, mem_ack,
        input  rsp_d, rsp_oe, ready, mem_req, mem_we, mem_addr, mem_wdata,
               io_strobe, io_port, io_data
    );

endinterface

// File: rtl/mem_responder_wr_buffer.sv
// ----------------------------------------------------------------------------
// wr_buffer
//   One-entry posted write buffer. A write is captured on load and presented
//   to memory (full=1) until the memory acknowledges it, which empties the
//   buffer.
//   Ports:
//     clk, rst             clock, synchronous active-high reset
//     load                 capture load_addr/load_data and mark full
//     load_addr, load_data write address and data to post
//     ack                  memory completion pulse for the posted write
//     full                 buffer holds a write awaiting completion
//     addr, data           contents of the buffer
// ----------------------------------------------------------------------------
module wr_buffer #(
    parameter int ADDR_W = 14
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [7:0]        load_data,
    input  logic              ack,
    output logic              full,
    output logic [ADDR_W-1:0] addr,
    output logic [7:0]        data
);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            full <= 1'b0;
            addr <= '0;
            data <= '0;
        end else if (load) begin
            full <= 1'b1;
            addr <= load_addr;
            data <= load_data;
        end else if (ack && full) begin
            full <= 1'b0;
        end
    end

endmodule

// File: rtl/mem_responder.sv
// ----------------------------------------------------------------------------
// mem_responder
//   Memory/I/O responder for an 8008 core model. It collects the address
//   from the T1/T2 bytes, performs memory reads (stalling the core with
//   ready=0), posts memory writes into a one-entry buffer so the core runs
//   on, injects an instruction on interrupt-acknowledge fetches and issues
//   a one-clock I/O strobe for I/O cycles.
//   Ports:
//     clk  clock (all state changes on posedge)
//     rst  synchronous, active-high reset
//     bus  mem_responder_if.slave - core, memory and I/O signals
// ----------------------------------------------------------------------------
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEFAULT
) (
    input logic            clk,
    input logic            rst,
    mem_responder_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        RD_HOLD = 2'd2,
        WR_ARM  = 2'd3
    } responder_state_t;

    // ------------------------------------------------------------------
    // Registers and their next values
    // ------------------------------------------------------------------
    responder_state_t rsp_state,   rsp_state_n;
    logic [7:0]       addr_lo,     addr_lo_n;
    logic [5:0]       addr_hi,     addr_hi_n;
    cyc_type_t        cyc,         cyc_n;
    logic             int_fetch,   int_fetch_n;
    logic [7:0]       rdbuf,       rdbuf_n;
    logic             ready_q,     ready_n;
    logic             rd_req,      rd_req_n;
    logic             pend,        pend_n;     // T2 seen while a write drains
    logic             io_strobe_q, io_strobe_n;
    logic [4:0]       io_port_q,   io_port_n;
    logic [7:0]       io_data_q,   io_data_n;

    // Cycle-start decision for the current edge
    logic             launch;
    cyc_type_t        launch_cyc;

    // Posted write buffer
    logic              wb_load;
    logic              wb_full;
    logic [ADDR_W-1:0] wb_addr;
    logic [7:0]        wb_data;

    logic [ADDR_W-1:0] cur_addr;
    logic              t1_edge, t2_edge, t3_edge;
    logic              drain_done, rd_done;

    assign cur_addr   = ADDR_W'({addr_hi, addr_lo});
    assign t1_edge    = bus.sync && is_addr_lo_state(bus.state);
    assign t2_edge    = bus.sync && (bus.state == T2);
    assign t3_edge    = bus.sync && (bus.state == T3);
    // Acks only count against the request actually outstanding; a stray ack
    // with nothing pending falls through both terms.
    assign drain_done = wb_full && bus.mem_ack;
    assign rd_done    = rd_req && !wb_full && bus.mem_ack;

    wr_buffer #(.ADDR_W(ADDR_W)) u_wr_buffer (
        .clk       (clk),
        .rst       (rst),
        .load      (wb_load),
        .load_addr (cur_addr),
        .load_data (bus.cpu_d),
        .ack       (bus.mem_ack),
        .full      (wb_full),
        .addr      (wb_addr),
        .data      (wb_data)
    );

    // ------------------------------------------------------------------
    // Next-state / next-output logic
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every variable assigned here gets a default first, so no
        // path leaves one unassigned and no latch is inferred.
        rsp_state_n = rsp_state;
        addr_lo_n   = addr_lo;
        addr_hi_n   = addr_hi;
        cyc_n       = cyc;
        int_fetch_n = int_fetch;
        rdbuf_n     = rdbuf;
        ready_n     = ready_q;
        rd_req_n    = rd_req;
        pend_n      = pend;
        io_strobe_n = 1'b0;
        io_port_n   = io_port_q;
        io_data_n   = io_data_q;
        wb_load     = 1'b0;
        launch      = 1'b0;
        launch_cyc  = cyc;

        if (t1_edge) begin
            addr_lo_n   = bus.cpu_d;
            int_fetch_n = (bus.state == T1I);
        end

        if (t2_edge) begin
            addr_hi_n = bus.cpu_d[5:0];
            cyc_n     = cyc_type_t'(bus.cpu_d[7:6]);
            if (wb_full && !bus.mem_ack) begin
                // Stall the core; the cycle starts once the drain completes.
                pend_n  = 1'b1;
                ready_n = 1'b0;
            end else begin
                launch     = 1'b1;
                launch_cyc = cyc_type_t'(bus.cpu_d[7:6]);
            end
        end else if (drain_done && pend) begin
            pend_n = 1'b0;
            launch = 1'b1;
        end

        case (rsp_state)
            IDLE: begin
                if (t3_edge && cyc == PCC && !pend) begin
                    io_strobe_n = 1'b1;
                    io_port_n   = addr_lo[5:1];
                    io_data_n   = bus.cpu_d;
                end
            end
            RD_WAIT: begin
                if (rd_done) begin
                    rdbuf_n     = bus.mem_rdata;
                    rd_req_n    = 1'b0;
                    ready_n     = 1'b1;
                    rsp_state_n = RD_HOLD;
                end
            end
            RD_HOLD: begin
                if (t1_edge) begin
                    rsp_state_n = IDLE;
                end
            end
            WR_ARM: begin
                if (t3_edge) begin
                    wb_load     = 1'b1;
                    rsp_state_n = IDLE;
                end
            end
            default: rsp_state_n = IDLE;
        endcase

        if (launch) begin
            case (launch_cyc)
                PCI, PCR: begin
                    if (launch_cyc == PCI && int_fetch) begin
                        // Interrupt acknowledge: feed the injected opcode.
                        rdbuf_n     = bus.int_instr;
                        ready_n     = 1'b1;
                        rsp_state_n = RD_HOLD;
                    end else begin
                        rd_req_n    = 1'b1;
                        ready_n     = 1'b0;
                        rsp_state_n = RD_WAIT;
                    end
                end
                PCC: begin
                    ready_n     = 1'b1;
                    rsp_state_n = IDLE;
                end
                PCW: begin
                    ready_n     = 1'b1;
                    rsp_state_n = WR_ARM;
                end
                default: rsp_state_n = IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_state   <= IDLE;
            addr_lo     <= '0;
            addr_hi     <= '0;
            cyc         <= PCI;
            int_fetch   <= 1'b0;
            rdbuf       <= '0;
            ready_q     <= 1'b1;
            rd_req      <= 1'b0;
            pend        <= 1'b0;
            io_strobe_q <= 1'b0;
            io_port_q   <= '0;
            io_data_q   <= '0;
        end else begin
            rsp_state   <= rsp_state_n;
            addr_lo     <= addr_lo_n;
            addr_hi     <= addr_hi_n;
            cyc         <= cyc_n;
            int_fetch   <= int_fetch_n;
            rdbuf       <= rdbuf_n;
            ready_q     <= ready_n;
            rd_req      <= rd_req_n;
            pend        <= pend_n;
            io_strobe_q <= io_strobe_n;
            io_port_q   <= io_port_n;
            io_data_q   <= io_data_n;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    // The drain owns the memory port whenever the buffer is full; a read is
    // never issued while it is.
    assign bus.mem_req   = wb_full || rd_req;
    assign bus.mem_we    = wb_full;
    assign bus.mem_addr  = wb_full ? wb_addr : (rd_req ? cur_addr : '0);
    assign bus.mem_wdata = wb_full ? wb_data : '0;

    // Read data (or 00 for an I/O cycle) is driven only while the core is in T3.
    assign bus.rsp_oe = (bus.state == T3) &&
                        ((rsp_state == RD_HOLD) ||
                         (rsp_state == IDLE && cyc == PCC && !pend));
    assign bus.rsp_d  = (bus.rsp_oe && rsp_state == RD_HOLD) ? rdbuf : 8'h00;

    assign bus.ready     = ready_q;
    assign bus.io_strobe = io_strobe_q;
    assign bus.io_port   = io_port_q;
    assign bus.io_data   = io_data_q;

endmodule

// File: tb/tb_mem_responder.sv
// ----------------------------------------------------------------------------
// tb_mem_responder
//   Directed testbench for mem_responder. Inputs change and outputs are
//   sampled on the falling clock edge; the responder acts on rising edges.
// ----------------------------------------------------------------------------
module tb_mem_responder;
    import mem_responder_pkg::*;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    mem_responder_if #(.ADDR_W(14)) bus ();

    mem_responder #(.ADDR_W(14)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "time limit exceeded");
    end

    // One core state entry: sync high across exactly one rising edge.
    task automatic enter(input state_t s, input logic [7:0] d);
        bus.state = s;
        bus.cpu_d = d;
        bus.sync  = 1'b1;
        @(negedge clk);
        bus.sync  = 1'b0;
    endtask

    task automatic check_idle_outputs(input string tag);
        checks++;
        if (bus.ready !== 1'b1 || bus.mem_req !== 1'b0 || bus.mem_we !== 1'b0 ||
            bus.rsp_oe !== 1'b0 || bus.io_strobe !== 1'b0) begin
            errors++;
            $display("FAIL %s_ctrl: got ready=%b req=%b we=%b oe=%b strobe=%b expected 1 0 0 0 0",
                     tag, bus.ready, bus.mem_req, bus.mem_we, bus.rsp_oe, bus.io_strobe);
        end
        checks++;
        if (bus.rsp_d !== 8'h00 || bus.mem_addr !== 14'h0000 || bus.mem_wdata !== 8'h00 ||
            bus.io_port !== 5'h00 || bus.io_data !== 8'h00) begin
            errors++;
            $display("FAIL %s_data: got rsp_d=%h addr=%h wdata=%h port=%h io=%h expected all zero",
                     tag, bus.rsp_d, bus.mem_addr, bus.mem_wdata, bus.io_port, bus.io_data);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check_idle_outputs("reset");
    endtask

    task automatic test_read();
        int low;
        low = 0;
        enter(T1, 8'h34);
        enter(T2, 8'h52);
        checks++;
        if (bus.mem_req !== 1'b1 || bus.mem_we !== 1'b0 || bus.mem_addr !== 14'h1234) begin
            errors++;
            $display("FAIL read_req: got req=%b we=%b addr=%h expected 1 0 1234",
                     bus.mem_req, bus.mem_we, bus.mem_addr);
        end
        if (bus.ready === 1'b0) low++;
        @(negedge clk);
        if (bus.ready === 1'b0) low++;
        @(negedge clk);
        if (bus.ready === 1'b0) low++;
        checks++;
        if (bus.mem_req !== 1'b1 || bus.mem_addr !== 14'h1234) begin
            errors++;
            $display("FAIL read_hold: got req=%b addr=%h expected 1 1234", bus.mem_req, bus.mem_addr);
        end
        bus.mem_rdata = 8'hA5;
        bus.mem_ack   = 1'b1;
        @(negedge clk);
        bus.mem_ack   = 1'b0;
        checks++;
        if (bus.ready !== 1'b1 || bus.mem_req !== 1'b0) begin
            errors++;
            $display("FAIL read_done: got ready=%b req=%b expected 1 0", bus.ready, bus.mem_req);
        end
        checks++;
        if (low !== 3) begin
            errors++;
            $display("FAIL read_ready_low: got %0d cycles expected 3", low);
        end
        enter(T3, 8'h00);
        checks++;
        if (bus.rsp_oe !== 1'b1 || bus.rsp_d !== 8'hA5) begin
            errors++;
            $display("FAIL read_t3: got oe=%b rsp_d=%h expected 1 a5", bus.rsp_oe, bus.rsp_d);
        end
        enter(T4, 8'h00);
        checks++;
        if (bus.rsp_oe !== 1'b0) begin
            errors++;
            $display("FAIL read_t4_oe: got %b expected 0", bus.rsp_oe);
        end
        enter(T5, 8'h00);
    endtask

    task automatic test_write();
        logic ready_dropped;
        ready_dropped = 1'b0;
        enter(T1, 8'h00);
        if (bus.ready !== 1'b1) ready_dropped = 1'b1;
        enter(T2, 8'hC1);
        if (bus.ready !== 1'b1) ready_dropped = 1'b1;
        checks++;
        if (bus.mem_req !== 1'b0) begin
            errors++;
            $display("FAIL write_t2_req: got %b expected 0", bus.mem_req);
        end
        enter(T3, 8'h5A);
        if (bus.ready !== 1'b1) ready_dropped = 1'b1;
        checks++;
        if (bus.mem_req !== 1'b1 || bus.mem_we !== 1'b1 ||
            bus.mem_addr !== 14'h0100 || bus.mem_wdata !== 8'h5A) begin
            errors++;
            $display("FAIL write_req: got req=%b we=%b addr=%h wdata=%h expected 1 1 0100 5a",
                     bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata);
        end
        enter(T4, 8'h00);
        if (bus.ready !== 1'b1) ready_dropped = 1'b1;
        bus.mem_ack = 1'b1;
        @(negedge clk);
        bus.mem_ack = 1'b0;
        if (bus.ready !== 1'b1) ready_dropped = 1'b1;
        checks++;
        if (bus.mem_req !== 1'b0 || bus.mem_we !== 1'b0) begin
            errors++;
            $display("FAIL write_drained: got req=%b we=%b expected 0 0", bus.mem_req, bus.mem_we);
        end
        checks++;
        if (ready_dropped !== 1'b0) begin
            errors++;
            $display("FAIL write_ready: got dropped=%b expected 0", ready_dropped);
        end
        enter(T5, 8'h00);
    endtask

    task automatic test_back_to_back();
        enter(T1, 8'h10);
        enter(T2, 8'hC2);
        enter(T3, 8'h3C);   // write posted: addr 0210, data 3c
        enter(T1, 8'h20);
        enter(T2, 8'h03);   // fetch from 0320 while the write still drains
        checks++;
        if (bus.ready !== 1'b0 || bus.mem_we !== 1'b1 || bus.mem_addr !== 14'h0210 ||
            bus.mem_wdata !== 8'h3C) begin
            errors++;
            $display("FAIL b2b_stall: got ready=%b we=%b addr=%h wdata=%h expected 0 1 0210 3c",
                     bus.ready, bus.mem_we, bus.mem_addr, bus.mem_wdata);
        end
        @(negedge clk);
        checks++;
        if (bus.ready !== 1'b0 || bus.mem_we !== 1'b1) begin
            errors++;
            $display("FAIL b2b_wait: got ready=%b we=%b expected 0 1", bus.ready, bus.mem_we);
        end
        bus.mem_ack = 1'b1;
        @(negedge clk);
        bus.mem_ack = 1'b0;
        checks++;
        if (bus.mem_req !== 1'b1 || bus.mem_we !== 1'b0 || bus.mem_addr !== 14'h0320 ||
            bus.ready !== 1'b0) begin
            errors++;
            $display("FAIL b2b_read_issue: got req=%b we=%b addr=%h ready=%b expected 1 0 0320 0",
                     bus.mem_req, bus.mem_we, bus.mem_addr, bus.ready);
        end
        bus.mem_rdata = 8'hC9;
        bus.mem_ack   = 1'b1;
        @(negedge clk);
        bus.mem_ack   = 1'b0;
        checks++;
        if (bus.ready !== 1'b1 || bus.mem_req !== 1'b0) begin
            errors++;
            $display("FAIL b2b_read_done: got ready=%b req=%b expected 1 0", bus.ready, bus.mem_req);
        end
        enter(T3, 8'h00);
        checks++;
        if (bus.rsp_oe !== 1'b1 || bus.rsp_d !== 8'hC9) begin
            errors++;
            $display("FAIL b2b_t3: got oe=%b rsp_d=%h expected 1 c9", bus.rsp_oe, bus.rsp_d);
        end
        enter(T4, 8'h00);
        enter(T5, 8'h00);
    endtask

    task automatic test_interrupt();
        logic saw_req;
        saw_req = 1'b0;
        bus.int_instr = 8'h0D;
        enter(T1I, 8'h55);
        if (bus.mem_req !== 1'b0) saw_req = 1'b1;
        enter(T2, 8'h00);
        if (bus.mem_req !== 1'b0) saw_req = 1'b1;
        checks++;
        if (bus.ready !== 1'b1) begin
            errors++;
            $display("FAIL int_ready: got %b expected 1", bus.ready);
        end
        enter(T3, 8'h00);
        if (bus.mem_req !== 1'b0) saw_req = 1'b1;
        checks++;
        if (bus.rsp_oe !== 1'b1 || bus.rsp_d !== 8'h0D) begin
            errors++;
            $display("FAIL int_t3: got oe=%b rsp_d=%h expected 1 0d", bus.rsp_oe, bus.rsp_d);
        end
        checks++;
        if (saw_req !== 1'b0) begin
            errors++;
            $display("FAIL int_no_req: got mem_req seen=%b expected 0", saw_req);
        end
        enter(T4, 8'h00);
        enter(T5, 8'h00);
    endtask

    task automatic test_io();
        int strobes;
        strobes = 0;
        enter(T1, 8'h14);
        enter(T2, 8'h80);
        if (bus.io_strobe === 1'b1) strobes++;
        checks++;
        if (bus.ready !== 1'b1 || bus.mem_req !== 1'b0) begin
            errors++;
            $display("FAIL io_t2: got ready=%b req=%b expected 1 0", bus.ready, bus.mem_req);
        end
        enter(T3, 8'h77);
        if (bus.io_strobe === 1'b1) strobes++;
        checks++;
        if (bus.io_strobe !== 1'b1 || bus.io_port !== 5'h0A || bus.io_data !== 8'h77) begin
            errors++;
            $display("FAIL io_strobe: got strobe=%b port=%h data=%h expected 1 0a 77",
                     bus.io_strobe, bus.io_port, bus.io_data);
        end
        checks++;
        if (bus.rsp_oe !== 1'b1 || bus.rsp_d !== 8'h00) begin
            errors++;
            $display("FAIL io_rsp: got oe=%b rsp_d=%h expected 1 00", bus.rsp_oe, bus.rsp_d);
        end
        @(negedge clk);
        if (bus.io_strobe === 1'b1) strobes++;
        enter(T4, 8'h00);
        if (bus.io_strobe === 1'b1) strobes++;
        enter(T5, 8'h00);
        if (bus.io_strobe === 1'b1) strobes++;
        checks++;
        if (strobes !== 1) begin
            errors++;
            $display("FAIL io_single: got %0d strobes expected 1", strobes);
        end
    endtask

    task automatic test_reset_mid();
        // Reset while a read waits for memory; the late ack must be ignored.
        enter(T1, 8'h34);
        enter(T2, 8'h52);
        checks++;
        if (bus.mem_req !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_pre: got req=%b expected 1", bus.mem_req);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_idle_outputs("rstmid_read");
        bus.mem_rdata = 8'hFF;
        bus.mem_ack   = 1'b1;
        @(negedge clk);
        bus.mem_ack   = 1'b0;
        check_idle_outputs("rstmid_stale_ack");
        enter(T3, 8'h00);
        checks++;
        if (bus.rsp_oe !== 1'b0 || bus.rsp_d !== 8'h00) begin
            errors++;
            $display("FAIL rstmid_t3: got oe=%b rsp_d=%h expected 0 00", bus.rsp_oe, bus.rsp_d);
        end
        enter(T4, 8'h00);
        enter(T5, 8'h00);
        // Reset with a posted write still buffered discards it.
        enter(T1, 8'h00);
        enter(T2, 8'hC1);
        enter(T3, 8'h11);
        checks++;
        if (bus.mem_req !== 1'b1 || bus.mem_we !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_wr_pre: got req=%b we=%b expected 1 1", bus.mem_req, bus.mem_we);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_idle_outputs("rstmid_write");
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        rst           = 1'b1;
        bus.state     = T4;
        bus.sync      = 1'b0;
        bus.cpu_d     = 8'h00;
        bus.int_instr = 8'h00;
        bus.mem_rdata = 8'h00;
        bus.mem_ack   = 1'b0;

        test_reset();
        test_read();
        test_write();
        test_back_to_back();
        test_interrupt();
        test_io();
        test_reset_mid();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
